// File: rtl/wb_regfile.sv
// rtl/wb_regfile.sv - RV32I writeback select, load extension, 32x32 register file with bypass
// Optional retire counter built only when WB_INSTRET_EN is defined.
module wb_regfile #(
   parameter int XLEN = 32,
   parameter int NREG = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [2:0]      WB_memtoReg,
   input  logic            WB_regWrite,
   input  logic            WB_memRead,
   input  logic [XLEN-1:0] WB_aluOut,
   input  logic [XLEN-1:0] WB_dmemOut,
   input  logic [XLEN-1:0] WB_imm,
   input  logic [XLEN-1:0] WB_pc_plus_four,
   input  logic [XLEN-1:0] WB_imm_plus_pc_or_rs1,
   input  logic [4:0]      WB_rd,
   input  logic [31:0]     WB_instr,
   input  logic [4:0]      ID_rs1,
   input  logic [4:0]      ID_rs2,
   output logic [XLEN-1:0] ID_rs1_data,
   output logic [XLEN-1:0] ID_rs2_data,
   output logic [XLEN-1:0] wb_data,
   output logic [63:0]     instret
);

   logic [XLEN-1:0] regs [0:NREG-1];
   logic [XLEN-1:0] load_data;
   logic [7:0]      load_byte;
   logic [15:0]     load_half;
   logic [2:0]      funct3;
   logic            wr_en;
   logic            unused_inputs;

   // Load classification is taken from the instruction itself; the memRead flag is redundant here.
   assign unused_inputs = ^{WB_memRead, WB_instr};

   assign funct3 = WB_instr[14:12];
   assign wr_en  = WB_regWrite && (WB_rd != 5'd0);

   always_comb begin
      load_byte = WB_dmemOut[7:0];
      case (WB_aluOut[1:0])
         2'd0: load_byte = WB_dmemOut[7:0];
         2'd1: load_byte = WB_dmemOut[15:8];
         2'd2: load_byte = WB_dmemOut[23:16];
         2'd3: load_byte = WB_dmemOut[31:24];
         default: load_byte = WB_dmemOut[7:0];
      endcase
      load_half = WB_aluOut[1] ? WB_dmemOut[31:16] : WB_dmemOut[15:0];
      case (funct3)
         3'b000:  load_data = {{(XLEN-8){load_byte[7]}}, load_byte};
         3'b100:  load_data = {{(XLEN-8){1'b0}}, load_byte};
         3'b001:  load_data = {{(XLEN-16){load_half[15]}}, load_half};
         3'b101:  load_data = {{(XLEN-16){1'b0}}, load_half};
         default: load_data = WB_dmemOut;
      endcase
   end

   always_comb begin
      case (WB_memtoReg)
         3'd0:    wb_data = WB_aluOut;
         3'd1:    wb_data = load_data;
         3'd2:    wb_data = WB_pc_plus_four;
         3'd3:    wb_data = WB_imm;
         3'd4:    wb_data = WB_imm_plus_pc_or_rs1;
         default: wb_data = '0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREG; i++) begin
            regs[i] <= '0;
         end
      end else if (wr_en) begin
         regs[WB_rd] <= wb_data;
      end
   end

   // Write-through: a read of the register being written this cycle sees the new value.
   always_comb begin
      if (ID_rs1 == 5'd0)
         ID_rs1_data = '0;
      else if (wr_en && (ID_rs1 == WB_rd))
         ID_rs1_data = wb_data;
      else
         ID_rs1_data = regs[ID_rs1];

      if (ID_rs2 == 5'd0)
         ID_rs2_data = '0;
      else if (wr_en && (ID_rs2 == WB_rd))
         ID_rs2_data = wb_data;
      else
         ID_rs2_data = regs[ID_rs2];
   end

`ifdef WB_INSTRET_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         instret <= '0;
      else if (WB_instr != 32'd0)
         instret <= instret + 64'd1;
   end
`else
   assign instret = '0;
`endif

endmodule

// File: tb/tb_wb_regfile.sv
// tb/tb_wb_regfile.sv - directed scoreboard bench for wb_regfile
module tb_wb_regfile;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [2:0]  WB_memtoReg = '0;
   logic        WB_regWrite = 1'b0;
   logic        WB_memRead = 1'b0;
   logic [31:0] WB_aluOut = '0;
   logic [31:0] WB_dmemOut = '0;
   logic [31:0] WB_imm = '0;
   logic [31:0] WB_pc_plus_four = '0;
   logic [31:0] WB_imm_plus_pc_or_rs1 = '0;
   logic [4:0]  WB_rd = '0;
   logic [31:0] WB_instr = '0;
   logic [4:0]  ID_rs1 = '0;
   logic [4:0]  ID_rs2 = '0;
   logic [31:0] ID_rs1_data;
   logic [31:0] ID_rs2_data;
   logic [31:0] wb_data;
   logic [63:0] instret;

   wb_regfile #(.XLEN(32), .NREG(32)) dut (
      .clk                   (clk),
      .rst_n                 (rst_n),
      .WB_memtoReg           (WB_memtoReg),
      .WB_regWrite           (WB_regWrite),
      .WB_memRead            (WB_memRead),
      .WB_aluOut             (WB_aluOut),
      .WB_dmemOut            (WB_dmemOut),
      .WB_imm                (WB_imm),
      .WB_pc_plus_four       (WB_pc_plus_four),
      .WB_imm_plus_pc_or_rs1 (WB_imm_plus_pc_or_rs1),
      .WB_rd                 (WB_rd),
      .WB_instr              (WB_instr),
      .ID_rs1                (ID_rs1),
      .ID_rs2                (ID_rs2),
      .ID_rs1_data           (ID_rs1_data),
      .ID_rs2_data           (ID_rs2_data),
      .wb_data               (wb_data),
      .instret               (instret)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       tag;
      logic [63:0] val;
   } exp_t;

   exp_t        sb[$];
   int          checks = 0;
   int          failures = 0;
   logic [63:0] n_ret = '0;

   typedef struct {
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [31:0] val;
   } load_case_t;

   load_case_t lc[8];

   task automatic push(input string tag, input logic [63:0] val);
      exp_t e;
      e.tag = tag;
      e.val = val;
      sb.push_back(e);
   endtask

   task automatic pop_check(input logic [63:0] obs);
      exp_t e;
      checks++;
      if (sb.size() == 0) begin
         failures++;
         $error("FAIL scoreboard_empty observed=%h", obs);
      end else begin
         e = sb.pop_front();
         assert (obs === e.val) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
         end
      end
   endtask

   task automatic step();
      @(posedge clk);
      if (rst_n && WB_instr != 32'd0) n_ret++;
      #1;
   endtask

   function automatic logic [63:0] exp_ret();
`ifdef WB_INSTRET_EN
      return n_ret;
`else
      return 64'd0;
`endif
   endfunction

   initial begin
      #100000;
      $display("FAIL timeout");
      $fatal(1, "timeout");
   end

   initial begin
      lc[0] = '{3'b000, 32'h3, 32'hFFFFFF80};
      lc[1] = '{3'b100, 32'h3, 32'h00000080};
      lc[2] = '{3'b001, 32'h0, 32'h00007F01};
      lc[3] = '{3'b101, 32'h2, 32'h000080FF};
      lc[4] = '{3'b001, 32'h1, 32'h00007F01};
      lc[5] = '{3'b000, 32'h1, 32'h0000007F};
      lc[6] = '{3'b010, 32'h3, 32'h80FF7F01};
      lc[7] = '{3'b011, 32'h0, 32'h80FF7F01};

      // reset state
      #2;
      step();
      for (int i = 1; i < 32; i++) begin
         ID_rs1 = i[4:0];
         #0.1;
         push($sformatf("reset_x%0d", i), 64'd0);
         pop_check({32'd0, ID_rs1_data});
      end
      push("reset_instret", 64'd0);
      pop_check(instret);
      step();
      rst_n = 1'b1;

      // ALU write with bypass
      WB_memtoReg = 3'd0; WB_aluOut = 32'hDEADBEEF; WB_rd = 5'd5;
      WB_regWrite = 1'b1; ID_rs1 = 5'd5; WB_instr = 32'h00000013;
      #1;
      push("alu_bypass", 64'hDEADBEEF);
      pop_check({32'd0, ID_rs1_data});
      step();
      WB_regWrite = 1'b0; WB_instr = 32'd0;
      #1;
      push("alu_array", 64'hDEADBEEF);
      pop_check({32'd0, ID_rs1_data});

      // load extension
      WB_dmemOut = 32'h80FF7F01; WB_memtoReg = 3'd1; WB_memRead = 1'b1;
      WB_rd = 5'd6; WB_regWrite = 1'b1;
      for (int k = 0; k < 8; k++) begin
         WB_instr = {17'd0, lc[k].f3, 5'd6, 7'b0000011};
         WB_aluOut = lc[k].addr;
         #1;
         push($sformatf("load_f3_%0d_off_%0d", lc[k].f3, lc[k].addr), {32'd0, lc[k].val});
         pop_check({32'd0, wb_data});
         step();
      end
      WB_regWrite = 1'b0; WB_memRead = 1'b0; WB_instr = 32'd0; ID_rs2 = 5'd6;
      #1;
      push("load_array", 64'h80FF7F01);
      pop_check({32'd0, ID_rs2_data});

      // x0 protection
      WB_memtoReg = 3'd0; WB_aluOut = 32'h1234; WB_rd = 5'd0; WB_regWrite = 1'b1;
      ID_rs1 = 5'd0; ID_rs2 = 5'd0;
      #1;
      push("x0_rs2_pre", 64'd0);
      pop_check({32'd0, ID_rs2_data});
      push("x0_rs1_pre", 64'd0);
      pop_check({32'd0, ID_rs1_data});
      push("x0_wb_data", 64'h1234);
      pop_check({32'd0, wb_data});
      step();
      WB_regWrite = 1'b0;
      #1;
      push("x0_rs2_post", 64'd0);
      pop_check({32'd0, ID_rs2_data});

      // select coverage
      WB_pc_plus_four = 32'h104; WB_imm = 32'hFFFFF800; WB_imm_plus_pc_or_rs1 = 32'h2000;
      WB_rd = 5'd7; ID_rs1 = 5'd7;
      for (int s = 2; s <= 4; s++) begin
         WB_memtoReg = s[2:0]; WB_regWrite = 1'b1;
         push($sformatf("sel%0d_array", s),
              (s == 2) ? 64'h104 : (s == 3) ? 64'hFFFFF800 : 64'h2000);
         step();
         WB_regWrite = 1'b0;
         #1;
         pop_check({32'd0, ID_rs1_data});
      end
      for (int s = 5; s <= 7; s++) begin
         WB_memtoReg = s[2:0];
         #1;
         push($sformatf("sel%0d_zero", s), 64'd0);
         pop_check({32'd0, wb_data});
      end

      // both ports bypass the same rd
      WB_memtoReg = 3'd0; WB_aluOut = 32'hA5A5C3C3; WB_rd = 5'd8; WB_regWrite = 1'b1;
      ID_rs1 = 5'd8; ID_rs2 = 5'd8;
      #1;
      push("dual_bypass_rs1", 64'hA5A5C3C3);
      pop_check({32'd0, ID_rs1_data});
      push("dual_bypass_rs2", 64'hA5A5C3C3);
      pop_check({32'd0, ID_rs2_data});
      step();
      WB_regWrite = 1'b0;

      // retire: three instructions and two bubbles
      WB_instr = 32'h00100093; step();
      WB_instr = 32'd0;        step();
      WB_instr = 32'h00208113; step();
      WB_instr = 32'd0;        step();
      WB_instr = 32'h00310193; step();
      WB_instr = 32'd0;
      #1;
      push("instret_count", exp_ret());
      pop_check(instret);

      // asynchronous reset between edges
      ID_rs1 = 5'd5; ID_rs2 = 5'd7;
      #1;
      rst_n = 1'b0;
      n_ret = '0;
      #1;
      push("async_rst_x5", 64'd0);
      pop_check({32'd0, ID_rs1_data});
      push("async_rst_x7", 64'd0);
      pop_check({32'd0, ID_rs2_data});
      push("async_rst_instret", 64'd0);
      pop_check(instret);

      // write during reset is discarded; first edge after release is normal
      WB_rd = 5'd9; WB_aluOut = 32'h55; WB_regWrite = 1'b1; WB_instr = 32'h00000013;
      step();
      #2;
      rst_n = 1'b1;
      WB_regWrite = 1'b0; ID_rs1 = 5'd9;
      #1;
      push("rst_write_dropped", 64'd0);
      pop_check({32'd0, ID_rs1_data});
      push("rst_instret_held", 64'd0);
      pop_check(instret);
      WB_regWrite = 1'b1;
      step();
      WB_regWrite = 1'b0; WB_instr = 32'd0;
      #1;
      push("post_rst_write", 64'h55);
      pop_check({32'd0, ID_rs1_data});
      push("post_rst_instret", exp_ret());
      pop_check(instret);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
